// File: rtl/my_dvi_pkg.sv
// Shared constants and types for the my_dvi TMDS test-pattern source.
// Holds control tokens, default 640x480 timing and the disparity counter type.
package my_dvi_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam logic [9:0] TOK_00 = 10'h354;
    localparam logic [9:0] TOK_01 = 10'h0AB;
    localparam logic [9:0] TOK_10 = 10'h154;
    localparam logic [9:0] TOK_11 = 10'h2AB;

    typedef logic signed [31:0] disp_t;

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

endpackage

// File: rtl/my_dvi_tmds_encoder.sv
// Combinational DVI 1.0 TMDS encoder for one lane.
// The caller owns the running-disparity register and feeds it back as prev_cnt.
module tmds_encoder
    import my_dvi_pkg::*;
(
    input  logic [7:0] d,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    input  disp_t      prev_cnt,
    output logic [9:0] tmds,
    output disp_t      cnt
);

    logic [3:0] n1_d;
    logic [3:0] n1_q;
    logic       use_xnor;
    logic [8:0] q_m;
    disp_t      n1s;
    disp_t      n0s;
    disp_t      diff;

    always_comb begin
        n1_d     = ones8(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);

        q_m    = '0;
        q_m[0] = d[0];
        for (int i = 1; i < 8; i++)
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
        q_m[8] = ~use_xnor;

        n1_q = ones8(q_m[7:0]);
        n1s  = $signed({28'd0, n1_q});
        n0s  = 32'sd8 - n1s;
        diff = n1s - n0s;

        tmds = '0;
        cnt  = prev_cnt;
        if (!de) begin
            cnt = '0;
            case ({c1, c0})
                2'b00:   tmds = TOK_00;
                2'b01:   tmds = TOK_01;
                2'b10:   tmds = TOK_10;
                default: tmds = TOK_11;
            endcase
        end else if ((prev_cnt == 0) || (n1s == n0s)) begin
            tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt  = prev_cnt + (q_m[8] ? diff : -diff);
        end else if (((prev_cnt > 0) && (n1s > n0s)) || ((prev_cnt < 0) && (n0s > n1s))) begin
            tmds = {1'b1, q_m[8], ~q_m[7:0]};
            cnt  = prev_cnt + (q_m[8] ? 32'sd2 : 32'sd0) - diff;
        end else begin
            tmds = {1'b0, q_m[8], q_m[7:0]};
            cnt  = prev_cnt - (q_m[8] ? 32'sd0 : 32'sd2) + diff;
        end
    end

endmodule

// File: rtl/my_dvi.sv
// DVI/TMDS test-pattern source: timing, three TMDS encoders, 10:1 serialisers.
// Define MY_DVI_COLOR_BARS_EN for 8 colour bars; otherwise active video is mid-grey.
module my_dvi
    import my_dvi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        tmds_clk,
    input  logic        rst_n,
    output logic        signal_R,
    output logic        signal_G,
    output logic        signal_B,
    output logic [9:0]  tst_tmds_r,
    output logic signed [31:0] tst_PrevBitCntR
);

    localparam logic [15:0] HA_W   = 16'(H_ACTIVE);
    localparam logic [15:0] HT_W   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VA_W   = 16'(V_ACTIVE);
    localparam logic [15:0] VT_W   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0]  bit_cnt;
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic        pix_stb;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [9:0]  sh_r, sh_g, sh_b;
    logic [9:0]  enc_r, enc_g, enc_b;
    disp_t       cnt_r, cnt_g, cnt_b;
    disp_t       nxt_r, nxt_g, nxt_b;

    assign pix_stb = (bit_cnt == 4'd9);
    assign de      = (h_cnt < HA_W) && (v_cnt < VA_W);
    assign hsync   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vsync   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

`ifdef MY_DVI_COLOR_BARS_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] idx;

    // Threshold chain instead of a divider: bar index is the number of bar edges passed.
    always_comb begin
        idx = '0;
        for (int k = 1; k < 8; k++)
            if (h_cnt >= 16'(k * BAR_W)) idx = 3'(k);
    end

    assign pix_r = {8{~idx[1]}};
    assign pix_g = {8{~idx[2]}};
    assign pix_b = {8{~idx[0]}};
`else
    assign pix_r = 8'h80;
    assign pix_g = 8'h80;
    assign pix_b = 8'h80;
`endif

    tmds_encoder u_enc_r (
        .d(pix_r), .c0(1'b0), .c1(1'b0), .de(de),
        .prev_cnt(cnt_r), .tmds(enc_r), .cnt(nxt_r)
    );
    tmds_encoder u_enc_g (
        .d(pix_g), .c0(1'b0), .c1(1'b0), .de(de),
        .prev_cnt(cnt_g), .tmds(enc_g), .cnt(nxt_g)
    );
    tmds_encoder u_enc_b (
        .d(pix_b), .c0(hsync), .c1(vsync), .de(de),
        .prev_cnt(cnt_b), .tmds(enc_b), .cnt(nxt_b)
    );

    always_ff @(posedge tmds_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            sh_r       <= '0;
            sh_g       <= '0;
            sh_b       <= '0;
            cnt_r      <= '0;
            cnt_g      <= '0;
            cnt_b      <= '0;
            tst_tmds_r <= '0;
        end else begin
            bit_cnt <= pix_stb ? 4'd0 : bit_cnt + 4'd1;
            if (pix_stb) begin
                sh_r       <= enc_r;
                sh_g       <= enc_g;
                sh_b       <= enc_b;
                tst_tmds_r <= enc_r;
                cnt_r      <= nxt_r;
                cnt_g      <= nxt_g;
                cnt_b      <= nxt_b;
                if (h_cnt == HT_W - 16'd1) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == VT_W - 16'd1) ? 16'd0 : v_cnt + 16'd1;
                end else begin
                    h_cnt <= h_cnt + 16'd1;
                end
            end else begin
                sh_r <= {1'b0, sh_r[9:1]};
                sh_g <= {1'b0, sh_g[9:1]};
                sh_b <= {1'b0, sh_b[9:1]};
            end
        end
    end

    // The shift registers reset to zero, so the lanes read zero until the first load.
    assign signal_R        = sh_r[0];
    assign signal_G        = sh_g[0];
    assign signal_B        = sh_b[0];
    assign tst_PrevBitCntR = cnt_r;

endmodule

// File: tb/tb_my_dvi.sv
// Directed bench for my_dvi on a shrunken 24x8 raster (16x4 active).
// Expected words/disparities are hand-computed for both pattern builds.
module tb_my_dvi;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

`ifdef MY_DVI_COLOR_BARS_EN
    localparam logic [9:0] W0 = 10'h200, W1 = 10'h0FF, W4 = 10'h3FF, W5 = 10'h100;
    localparam int C0 = -8, C1 = -2, C4 = 6, C5 = -2;
`else
    localparam logic [9:0] W0 = 10'h180, W1 = 10'h37F, W4 = 10'h180, W5 = 10'h37F;
    localparam int C0 = -6, C1 = 2, C4 = -2, C5 = 6;
`endif

    logic        clk;
    logic        rst_n;
    logic        signal_R, signal_G, signal_B;
    logic [9:0]  tst_tmds_r;
    logic signed [31:0] tst_PrevBitCntR;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;
    logic [9:0] cap_r, cap_g, cap_b;

    my_dvi #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .tmds_clk(clk),
        .rst_n(rst_n),
        .signal_R(signal_R),
        .signal_G(signal_G),
        .signal_B(signal_B),
        .tst_tmds_r(tst_tmds_r),
        .tst_PrevBitCntR(tst_PrevBitCntR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Edges are counted from reset release; sampling is 1 time unit after the edge.
    task automatic step_to(input int e);
        while (edge_cnt < e) begin
            @(posedge clk);
            edge_cnt++;
        end
        #1;
    endtask

    // Called right after a load edge: collects the 10 serial bits of each lane.
    task automatic capture();
        cap_r[0] = signal_R; cap_g[0] = signal_G; cap_b[0] = signal_B;
        for (int i = 1; i < 10; i++) begin
            step_to(edge_cnt + 1);
            cap_r[i] = signal_R; cap_g[i] = signal_G; cap_b[i] = signal_B;
        end
    endtask

    function automatic int load_edge(input int h, input int v);
        return 10 * (v * HT + h + 1);
    endfunction

    task automatic release_and_check_start(input string pfx);
        @(negedge clk);
        rst_n    = 1'b1;
        edge_cnt = 0;
        for (int e = 1; e < 10; e++) begin
            step_to(e);
            check({pfx, "_lanes_idle"}, {29'd0, signal_R, signal_G, signal_B}, 32'd0);
        end
        check({pfx, "_tmds_pre"}, {22'd0, tst_tmds_r}, 32'd0);
        step_to(10);
        check({pfx, "_w0"}, {22'd0, tst_tmds_r}, {22'd0, W0});
        check({pfx, "_c0"}, tst_PrevBitCntR, C0);
        capture();
        check({pfx, "_ser_r0"}, {22'd0, cap_r}, {22'd0, W0});
        check({pfx, "_ser_g0"}, {22'd0, cap_g}, {22'd0, W0});
        check({pfx, "_ser_b0"}, {22'd0, cap_b}, {22'd0, W0});
        step_to(20);
        check({pfx, "_w1"}, {22'd0, tst_tmds_r}, {22'd0, W1});
        check({pfx, "_c1"}, tst_PrevBitCntR, C1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lanes", {29'd0, signal_R, signal_G, signal_B}, 32'd0);
        check("rst_tmds", {22'd0, tst_tmds_r}, 32'd0);
        check("rst_cnt", tst_PrevBitCntR, 32'd0);

        release_and_check_start("a");

        step_to(load_edge(4, 0));
        check("h4_w", {22'd0, tst_tmds_r}, {22'd0, W4});
        check("h4_c", tst_PrevBitCntR, C4);
        step_to(load_edge(5, 0));
        check("h5_w", {22'd0, tst_tmds_r}, {22'd0, W5});
        check("h5_c", tst_PrevBitCntR, C5);

        step_to(load_edge(HA, 0));
        check("fp_red", {22'd0, tst_tmds_r}, 32'h354);
        check("fp_cnt", tst_PrevBitCntR, 32'd0);
        capture();
        check("fp_blue", {22'd0, cap_b}, 32'h2AB);
        check("fp_green", {22'd0, cap_g}, 32'h354);

        step_to(load_edge(HA + HFP, 0));
        capture();
        check("hs_first_blue", {22'd0, cap_b}, 32'h154);
        step_to(load_edge(HA + HFP + HS - 1, 0));
        capture();
        check("hs_last_blue", {22'd0, cap_b}, 32'h154);
        step_to(load_edge(HA + HFP + HS, 0));
        capture();
        check("bp_blue", {22'd0, cap_b}, 32'h2AB);

        step_to(load_edge(0, VA + VFP));
        check("vs_red", {22'd0, tst_tmds_r}, 32'h354);
        capture();
        check("vs_blue", {22'd0, cap_b}, 32'h0AB);
        step_to(load_edge(HA + HFP, VA + VFP + VS - 1));
        capture();
        check("vs_hs_blue", {22'd0, cap_b}, 32'h354);

        step_to(load_edge(0, VT));
        check("frame2_w0", {22'd0, tst_tmds_r}, {22'd0, W0});
        check("frame2_c0", tst_PrevBitCntR, C0);
        step_to(load_edge(1, VT));
        check("frame2_w1", {22'd0, tst_tmds_r}, {22'd0, W1});
        check("frame2_c1", tst_PrevBitCntR, C1);

        step_to(load_edge(1, VT) + 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tmds", {22'd0, tst_tmds_r}, 32'd0);
        check("mid_rst_cnt", tst_PrevBitCntR, 32'd0);
        check("mid_rst_lanes", {29'd0, signal_R, signal_G, signal_B}, 32'd0);
        repeat (2) @(posedge clk);

        release_and_check_start("b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
